// File: rtl/mips_dmem_io.sv
`default_nettype none
// ============================================================================
// Module      : mips_dmem_io
// Description : Data-memory port of the 8-bit MIPS core. Holds 240 B of RAM
//               and memory-mapped UART TX (with FIFO), STATUS and GPIO
//               registers. Reads are registered with one cycle of latency and
//               return the value the location held before any write on the
//               same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem_io #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_mem_rw_addr,
  input  logic [7:0] i_mem_w,
  input  logic       i_mem_w_en,
  output logic [7:0] o_mem_r,
  input  logic [7:0] i_gpio_in,
  output logic [7:0] o_gpio_out,
  output logic       o_uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_last_clk = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   c_full_cnt = (AW+1)'(FIFO_DEPTH);

  localparam logic [7:0] c_addr_txdata = 8'hF0;
  localparam logic [7:0] c_addr_status = 8'hF1;
  localparam logic [7:0] c_addr_gpo    = 8'hF2;
  localparam logic [7:0] c_addr_gpi    = 8'hF3;
  localparam logic [7:0] c_ram_top     = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  logic [7:0]  r_ram [0:239];
  logic [7:0]  r_fifo [0:FIFO_DEPTH-1];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0] r_count;
  logic        r_ovf;
  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  uart_state_t r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;

  logic        w_full;
  logic        w_empty;
  logic        w_busy;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_ram_sel;
  logic [7:0]  w_status;
  logic [7:0]  w_rdata;

  assign w_full     = (r_count == c_full_cnt);
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_ram_sel  = (i_mem_rw_addr < c_ram_top);
  assign w_push_req = i_mem_w_en && (i_mem_rw_addr == c_addr_txdata);
  // Fullness is judged before the edge, so a pop on the same edge does not rescue a push.
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_status   = {4'b0, r_ovf, w_busy, w_empty, w_full};

  // Read mux: RAM below 0xF0, then the register window, reserved reads as zero.
  always_comb begin
    w_rdata = 8'h00;
    if (w_ram_sel) begin
      w_rdata = r_ram[i_mem_rw_addr];
    end else begin
      case (i_mem_rw_addr)
        c_addr_status: w_rdata = w_status;
        c_addr_gpo:    w_rdata = o_gpio_out;
        c_addr_gpi:    w_rdata = r_sync2;
        default:       w_rdata = 8'h00;
      endcase
    end
  end

  // RAM and FIFO storage are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_mem_w_en && w_ram_sel) r_ram[i_mem_rw_addr] <= i_mem_w;
    if (w_push) r_fifo[r_wr_ptr] <= i_mem_w;
  end

  // Registered read data, GPIO output register, input synchronizer and OVF flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_mem_r    <= 8'h00;
      o_gpio_out <= 8'h00;
      r_sync1    <= 8'h00;
      r_sync2    <= 8'h00;
      r_ovf      <= 1'b0;
    end else begin
      o_mem_r <= w_rdata;
      r_sync1 <= i_gpio_in;
      r_sync2 <= r_sync1;
      if (i_mem_w_en && (i_mem_rw_addr == c_addr_gpo)) o_gpio_out <= i_mem_w;
      if (i_mem_w_en && (i_mem_rw_addr == c_addr_status)) r_ovf <= 1'b0;
      else if (w_push_req && w_full) r_ovf <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // UART 8N1 transmitter; the line level is a registered output of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      o_uart_tx <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_uart_tx <= 1'b1;
          r_clk_cnt <= '0;
          if (w_pop) begin
            r_shift   <= r_fifo[r_rd_ptr];
            o_uart_tx <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (r_clk_cnt == c_last_clk) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            o_uart_tx <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == c_last_clk) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              o_uart_tx <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              o_uart_tx <= r_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          o_uart_tx <= 1'b1;
          if (r_clk_cnt == c_last_clk) begin
            r_clk_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          o_uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
